// File: rtl/paramul_pkg.sv
// Shared types for the paramul multiplier path: Booth digit set, control FSM
// states and the radix-4 digit decoder.
package paramul_pkg;
  localparam int PARAMUL_WIDTH = 32;

  typedef enum logic [2:0] {BOOTH_ZERO, BOOTH_P1, BOOTH_P2, BOOTH_M1, BOOTH_M2} booth_e;
  typedef enum logic [1:0] {IDLE, ACCUM, FIXUP, DONE} state_e;

  function automatic booth_e booth_decode(input logic [2:0] win);
    case (win)
      3'b001, 3'b010: return BOOTH_P1;
      3'b011:         return BOOTH_P2;
      3'b100:         return BOOTH_M2;
      3'b101, 3'b110: return BOOTH_M1;
      default:        return BOOTH_ZERO;
    endcase
  endfunction
endpackage

// File: rtl/booth_csa_mul_seq_pp_sel.sv
// Radix-4 Booth partial-product selector. Negative digits emit the one's
// complement; the +1 is supplied later through neg_vec.
module booth_pp_sel
  import paramul_pkg::*;
#(
  parameter int WIDTH  = PARAMUL_WIDTH,
  parameter int SIGNED = 1,
  parameter int IW     = $clog2(WIDTH/2+2)
) (
  input  logic [WIDTH-1:0]   m,
  input  logic [2:0]         win,
  input  logic [IW-1:0]      idx,
  output logic [2*WIDTH-1:0] pp,
  output logic               neg
);
  localparam int PW = 2*WIDTH;

  booth_e        dig;
  logic          sgn;
  logic [PW-1:0] mx, x;

  always_comb begin
    dig = booth_decode(win);
    sgn = (SIGNED != 0) && m[WIDTH-1];
    // Extending before the x2 keeps the most-negative multiplicand exact.
    mx  = {{WIDTH{sgn}}, m};
    x   = '0;
    neg = 1'b0;
    case (dig)
      BOOTH_P1: x = mx;
      BOOTH_P2: x = mx << 1;
      BOOTH_M1: begin x = ~mx;        neg = 1'b1; end
      BOOTH_M2: begin x = ~(mx << 1); neg = 1'b1; end
      default:  x = '0;
    endcase
    pp = x << {idx, 1'b0};
  end
endmodule

// File: rtl/booth_csa_mul_seq.sv
// Iterative radix-4 Booth multiplier front end: one 3:2 row per clock, result
// left as a carry-save pair for the downstream carry-propagate adder.
module booth_csa_mul_seq
  import paramul_pkg::*;
#(
  parameter int WIDTH  = PARAMUL_WIDTH,
  parameter int SIGNED = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] sum_vec,
  output logic [2*WIDTH-1:0] carry_vec,
  output logic               busy
);
  localparam int PW     = 2*WIDTH;
  localparam int N_ITER = (SIGNED != 0) ? WIDTH/2 : WIDTH/2 + 1;
  localparam int IW     = $clog2(WIDTH/2+2);
  localparam logic [IW-1:0] LAST = IW'(N_ITER-1);

  state_e           state;
  logic [WIDTH-1:0] m, q;
  logic [IW-1:0]    i;
  logic [PW-1:0]    neg_vec;

  logic             ext, pp_neg;
  logic [WIDTH+2:0] qx;
  logic [2:0]       win;
  logic [PW-1:0]    pp, row_in, sum_nxt, carry_nxt;

  // Q[-1] = 0 at the bottom; two extension bits on top feed the last digits.
  assign ext = (SIGNED != 0) && q[WIDTH-1];
  assign qx  = {ext, ext, q, 1'b0};
  assign win = qx[{i, 1'b0} +: 3];

  booth_pp_sel #(.WIDTH(WIDTH), .SIGNED(SIGNED), .IW(IW)) u_pp_sel (
    .m   (m),
    .win (win),
    .idx (i),
    .pp  (pp),
    .neg (pp_neg)
  );

  assign row_in    = (state == FIXUP) ? neg_vec : pp;
  assign sum_nxt   = sum_vec ^ carry_vec ^ row_in;
  assign carry_nxt = ((sum_vec & carry_vec) | (sum_vec & row_in) | (carry_vec & row_in)) << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      m         <= '0;
      q         <= '0;
      i         <= '0;
      sum_vec   <= '0;
      carry_vec <= '0;
      neg_vec   <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          m         <= a_in;
          q         <= b_in;
          i         <= '0;
          sum_vec   <= '0;
          carry_vec <= '0;
          neg_vec   <= '0;
          in_ready  <= 1'b0;
          busy      <= 1'b1;
          state     <= ACCUM;
        end
        ACCUM: begin
          sum_vec   <= sum_nxt;
          carry_vec <= carry_nxt;
          if (pp_neg) neg_vec[{i, 1'b0}] <= 1'b1;
          if (i == LAST) state <= FIXUP;
          else           i     <= i + IW'(1);
        end
        FIXUP: begin
          sum_vec   <= sum_nxt;
          carry_vec <= carry_nxt;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_csa_mul_seq.sv
// Bench for booth_csa_mul_seq: signed and unsigned instances side by side,
// expected products queued at acceptance and compared when out_valid rises.
module tb_booth_csa_mul_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         iv_s = 1'b0, iv_u = 1'b0, or_s = 1'b1, or_u = 1'b1;
  logic [W-1:0] a_s = '0, b_s = '0, a_u = '0, b_u = '0;
  logic         ir_s, ov_s, busy_s, ir_u, ov_u, busy_u;
  logic [2*W-1:0] sv_s, cv_s, sv_u, cv_u;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  booth_csa_mul_seq #(.WIDTH(W), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_s), .in_ready(ir_s),
    .a_in(a_s), .b_in(b_s), .out_valid(ov_s), .out_ready(or_s),
    .sum_vec(sv_s), .carry_vec(cv_s), .busy(busy_s)
  );

  booth_csa_mul_seq #(.WIDTH(W), .SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_u), .in_ready(ir_u),
    .a_in(a_u), .b_in(b_u), .out_valid(ov_u), .out_ready(or_u),
    .sum_vec(sv_u), .carry_vec(cv_u), .busy(busy_u)
  );

  function automatic logic f_ir(input bit u);   return u ? ir_u : ir_s;     endfunction
  function automatic logic f_ov(input bit u);   return u ? ov_u : ov_s;     endfunction
  function automatic logic f_busy(input bit u); return u ? busy_u : busy_s; endfunction
  // Model of the downstream carry-propagate adder.
  function automatic logic [63:0] f_red(input bit u);
    return u ? (sv_u + cv_u) : (sv_s + cv_s);
  endfunction
  function automatic logic f_vec_zero(input bit u);
    return u ? (sv_u == '0 && cv_u == '0) : (sv_s == '0 && cv_s == '0);
  endfunction

  function automatic logic [63:0] ref_mul(input bit u, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa, xb;
    xa = u ? {32'b0, a} : {{32{a[31]}}, a};
    xb = u ? {32'b0, b} : {{32{b[31]}}, b};
    return xa * xb;
  endfunction

  task automatic drive(input bit u, input logic v, input logic [31:0] a, input logic [31:0] b);
    if (u) begin iv_u = v; a_u = a; b_u = b; end
    else   begin iv_s = v; a_s = a; b_s = b; end
  endtask

  task automatic start_op(input bit u, input logic [31:0] a, input logic [31:0] b, input logic [63:0] e);
    int t = 0;
    @(negedge clk);
    while (!f_ir(u) && t < 100) begin @(negedge clk); t++; end
    checks++;
    if (!f_ir(u)) begin
      errors++;
      $display("FAIL start_op: in_ready=0 after %0d cycles, required 1", t);
    end
    drive(u, 1'b1, a, b);
    @(posedge clk);
    exp_q.push_back(e);
    #1 drive(u, 1'b0, a, b);
  endtask

  task automatic wait_result(input bit u, input int lat, input string nm, output logic [63:0] e);
    int n = 0;
    e = '0;
    do begin @(posedge clk); #1; n++; end while (!f_ov(u) && n < 60);
    checks++;
    if (!f_ov(u)) begin
      errors++;
      $display("FAIL %s: out_valid not seen within %0d cycles, required within %0d", nm, n, lat);
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: out_valid=1 with no operation outstanding", nm);
    end else begin
      if (lat > 0) begin
        checks++;
        if (n !== lat) begin
          errors++;
          $display("FAIL %s_latency: got %0d cycles, required %0d", nm, n, lat);
        end
      end
      e = exp_q.pop_front();
      checks++;
      if (f_red(u) !== e) begin
        errors++;
        $display("FAIL %s: sum+carry=%h, required %h", nm, f_red(u), e);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (f_ov(u) !== 1'b0 || f_busy(u) !== 1'b0 || f_vec_zero(u) !== 1'b1) begin
        errors++;
        $display("FAIL reset_state[%0d]: out_valid=%b busy=%b vec_zero=%b, required 0 0 1",
                 u, f_ov(u), f_busy(u), f_vec_zero(u));
      end
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (f_ir(u) !== 1'b1) begin
        errors++;
        $display("FAIL reset_in_ready[%0d]: got %b, required 1", u, f_ir(u));
      end
    end
  endtask

  task automatic test_basic();
    logic [63:0] e;
    start_op(0, 32'd3, 32'd5, 64'h000000000000000F);
    wait_result(0, 17, "basic_3x5", e);
    @(posedge clk); #1;
    checks++;
    if (ov_s !== 1'b0 || ir_s !== 1'b1) begin
      errors++;
      $display("FAIL done_one_cycle: out_valid=%b in_ready=%b, required 0 1", ov_s, ir_s);
    end
  endtask

  task automatic test_corners();
    logic [63:0] e;
    start_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001);
    wait_result(0, 17, "signed_m1xm1", e);
    start_op(0, 32'h80000000, 32'h80000000, 64'h4000000000000000);
    wait_result(0, 17, "signed_minxmin", e);
    start_op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
    wait_result(1, 18, "unsigned_max", e);
    start_op(1, 32'h80000000, 32'h00000002, 64'h0000000100000000);
    wait_result(1, 18, "unsigned_top_bit", e);
  endtask

  task automatic test_backpressure();
    logic [63:0] e;
    or_s = 1'b0;
    start_op(0, 32'd100, 32'hFFFFFFFD, 64'hFFFFFFFFFFFFFED4);
    wait_result(0, 17, "bp_first", e);
    drive(0, 1'b1, 32'd7, 32'd7);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      checks++;
      if (ov_s !== 1'b1 || ir_s !== 1'b0 || busy_s !== 1'b0 || f_red(0) !== 64'hFFFFFFFFFFFFFED4) begin
        errors++;
        $display("FAIL bp_hold[%0d]: ov=%b ir=%b busy=%b sum+carry=%h, required 1 0 0 fffffffffffffed4",
                 k, ov_s, ir_s, busy_s, f_red(0));
      end
    end
    drive(0, 1'b0, 32'd7, 32'd7);
    or_s = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ov_s !== 1'b0 || ir_s !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", ov_s, ir_s);
    end
    start_op(0, 32'd7, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFF2);
    wait_result(0, 17, "bp_next", e);
  endtask

  task automatic test_back_to_back();
    logic [63:0] e;
    start_op(0, 32'hDEADBEEF, 32'h00001235, ref_mul(0, 32'hDEADBEEF, 32'h00001235));
    drive(0, 1'b1, 32'd9, 32'd9);
    wait_result(0, 17, "b2b_busy_ignore", e);
    drive(0, 1'b0, 32'd9, 32'd9);
    start_op(0, 32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000);
    wait_result(0, 17, "b2b_second", e);
  endtask

  task automatic test_reset_mid();
    logic [63:0] e;
    logic seen;
    start_op(0, 32'h1234, 32'h5678, 64'h0000000006260060);
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ov_s !== 1'b0 || busy_s !== 1'b0 || f_vec_zero(0) !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_async: ov=%b busy=%b vec_zero=%b, required 0 0 1", ov_s, busy_s, f_vec_zero(0));
    end
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ir_s !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_ready: in_ready=%b, required 1", ir_s);
    end
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (ov_s) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_valid: out_valid pulse seen=%b, required 0", seen);
    end
    start_op(0, 32'd12, 32'd12, 64'd144);
    wait_result(0, 17, "reset_mid_next", e);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h80000000;
      1: return 32'hFFFFFFFF;
      2: return 32'h00000000;
      3: return 32'h7FFFFFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic test_random();
    logic [63:0] e;
    logic [31:0] a, b;
    bit u;
    for (int k = 0; k < 2000; k++) begin
      u = k[0];
      a = pick();
      b = pick();
      start_op(u, a, b, ref_mul(u, a, b));
      wait_result(u, u ? 18 : 17, "random", e);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
